// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds PC and IR, decodes IR fields, and resolves
// conditional branches against ALU status. Halts permanently on HLT until reset.
module fetch_unit (
  input  logic        clk,
  input  logic        rst_f,
  input  logic        pc_write,
  input  logic        br_en,
  input  logic [3:0]  stat,
  input  logic [31:0] im_data,
  output logic [15:0] pc_out,
  output logic [3:0]  opcode,
  output logic [3:0]  mm,
  output logic [3:0]  rd,
  output logic [3:0]  rs,
  output logic [3:0]  rt,
  output logic [15:0] imm,
  output logic        br_taken,
  output logic        halted,
  output logic [15:0] instr_cnt
);

  localparam logic [3:0] OP_BRA = 4'b0100;
  localparam logic [3:0] OP_BRR = 4'b0101;
  localparam logic [3:0] OP_BNE = 4'b0110;
  localparam logic [3:0] OP_BNR = 4'b0111;
  localparam logic [3:0] OP_HLT = 4'b1111;

  logic [15:0] pc_p0;
  logic [31:0] ir_p0;
  logic [15:0] cnt_p0;
  logic        halt_p0;
  logic        bt_p0;

  logic        cond;
  logic        taken;
  logic [15:0] target;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? 16'hFFFF : v + 16'd1;
  endfunction

  // Branch resolution always looks at the IR and PC held before the edge
  always_comb begin
    cond   = |(stat & ir_p0[27:24]);
    taken  = 1'b0;
    target = ir_p0[15:0];
    unique case (ir_p0[31:28])
      OP_BRA: taken = cond;
      OP_BRR: begin
        taken  = cond;
        target = pc_p0 + ir_p0[15:0];
      end
      OP_BNE: taken = ~cond;
      OP_BNR: begin
        taken  = ~cond;
        target = pc_p0 + ir_p0[15:0];
      end
      default: taken = 1'b0;
    endcase
  end

  // ---- state update: fetch, then branch redirect overrides PC ----
  always_ff @(posedge clk) begin
    if (!rst_f) begin
      pc_p0   <= 16'h0000;
      ir_p0   <= 32'h0;
      cnt_p0  <= 16'h0000;
      halt_p0 <= 1'b0;
      bt_p0   <= 1'b0;
    end else begin
      bt_p0 <= 1'b0;
      if (!halt_p0) begin
        if (pc_write) begin
          ir_p0   <= im_data;
          pc_p0   <= pc_p0 + 16'd1;
          cnt_p0  <= sat_inc(cnt_p0);
          halt_p0 <= (im_data[31:28] == OP_HLT);
        end
        if (br_en && taken) begin
          pc_p0 <= target;
          bt_p0 <= 1'b1;
        end
      end
    end
  end

  assign pc_out    = pc_p0;
  assign opcode    = ir_p0[31:28];
  assign mm        = ir_p0[27:24];
  assign rd        = ir_p0[23:20];
  assign rs        = ir_p0[19:16];
  assign rt        = ir_p0[15:12];
  assign imm       = ir_p0[15:0];
  assign br_taken  = bt_p0;
  assign halted    = halt_p0;
  assign instr_cnt = cnt_p0;

endmodule
